// File: rtl/axis_pkg.sv
// Shared types and helpers for AXI-Stream arbitration blocks.
package axis_pkg;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } arb_state_t;

   // Wrapping increment; n need not be a power of two.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping modulo N.
module rr_priority_select #(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   localparam logic [IDX_W:0] NumW = (IDX_W + 1)'(N);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [IDX_W:0] w_off;
   logic [IDX_W:0] w_sum;

   // Rotate so bit 0 is the request at i_ptr.
   assign w_dbl = {i_req, i_req};
   assign w_rot = N'(w_dbl >> i_ptr);

   always_comb begin
      o_found = 1'b0;
      w_off   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            o_found = 1'b1;
            w_off   = (IDX_W + 1)'(i);
         end
      end
   end

   assign w_sum = {1'b0, i_ptr} + w_off;
   assign o_idx = (w_sum >= NumW) ? IDX_W'(w_sum - NumW) : w_sum[IDX_W-1:0];

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink among NUM_INPUTS sources.
module axis_packet_arbiter
   import axis_pkg::*;
#(
   parameter int unsigned AXIS_BYTES = 1,
   parameter int unsigned NUM_INPUTS = 4,
   localparam int unsigned IDX_W = $clog2(NUM_INPUTS)
) (
   input  logic                               clk,
   input  logic                               sresetn,
   input  logic [NUM_INPUTS-1:0]              axis_i_tvalid,
   output logic [NUM_INPUTS-1:0]              axis_i_tready,
   input  logic [NUM_INPUTS-1:0]              axis_i_tlast,
   input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
   input  logic                               axis_o_tready,
   output logic                               axis_o_tvalid,
   output logic                               axis_o_tlast,
   output logic [AXIS_BYTES*8-1:0]            axis_o_tdata,
   output logic [IDX_W-1:0]                   grant_idx,
   output logic                               busy
);

   localparam int unsigned DataW = AXIS_BYTES * 8;

   typedef struct packed {
      logic [DataW-1:0] tdata;
      logic             tlast;
   } axis_beat_t;

   arb_state_t       r_state;
   arb_state_t       w_state_d;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] w_grant_d;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] w_rr_ptr_d;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_found;
   logic             w_sel_valid;
   logic             w_last_xfer;
   axis_beat_t       w_beats [NUM_INPUTS];
   axis_beat_t       w_sel_beat;

   for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_beat
      assign w_beats[n].tdata = axis_i_tdata[n*DataW +: DataW];
      assign w_beats[n].tlast = axis_i_tlast[n];
   end

   rr_priority_select #(
      .N (NUM_INPUTS)
   ) u_select (
      .i_req   (axis_i_tvalid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   assign w_sel_beat  = w_beats[r_grant_idx];
   assign w_sel_valid = axis_i_tvalid[r_grant_idx];

   // Sink ready reaches only the granted source; everything else is held off.
   always_comb begin
      axis_i_tready = '0;
      axis_o_tvalid = 1'b0;
      if (r_state == StGrant) begin
         axis_i_tready[r_grant_idx] = axis_o_tready;
         axis_o_tvalid              = w_sel_valid;
      end
   end

   assign axis_o_tdata = w_sel_beat.tdata;
   assign axis_o_tlast = w_sel_beat.tlast;
   assign w_last_xfer  = (r_state == StGrant) & w_sel_valid & axis_o_tready & w_sel_beat.tlast;

   always_comb begin
      w_state_d  = r_state;
      w_grant_d  = r_grant_idx;
      w_rr_ptr_d = r_rr_ptr;
      case (r_state)
         StIdle: begin
            if (w_pick_found) begin
               w_state_d = StGrant;
               w_grant_d = w_pick_idx;
            end
         end
         StGrant: begin
            if (w_last_xfer) begin
               w_state_d  = StIdle;
               w_rr_ptr_d = IDX_W'(rr_next(32'(r_grant_idx), NUM_INPUTS));
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         r_state     <= StIdle;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_state     <= w_state_d;
         r_grant_idx <= w_grant_d;
         r_rr_ptr    <= w_rr_ptr_d;
      end
   end

   assign grant_idx = r_grant_idx;
   assign busy      = (r_state == StGrant);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench: 4-input and 3-input arbiters against a queue-based round-robin model.
module tb_axis_packet_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [3:0]  a_tvalid, a_tready, a_tlast;
   logic [31:0] a_tdata;
   logic        a_oready, a_ovalid, a_olast;
   logic [7:0]  a_odata;
   logic [1:0]  a_gidx;
   logic        a_busy;

   logic [2:0]  b_tvalid, b_tready, b_tlast;
   logic [23:0] b_tdata;
   logic        b_oready, b_ovalid, b_olast;
   logic [7:0]  b_odata;
   logic [1:0]  b_gidx;
   logic        b_busy;

   axis_packet_arbiter #(
      .AXIS_BYTES (1),
      .NUM_INPUTS (4)
   ) u_dut4 (
      .clk           (clk),
      .sresetn       (rst_n),
      .axis_i_tvalid (a_tvalid),
      .axis_i_tready (a_tready),
      .axis_i_tlast  (a_tlast),
      .axis_i_tdata  (a_tdata),
      .axis_o_tready (a_oready),
      .axis_o_tvalid (a_ovalid),
      .axis_o_tlast  (a_olast),
      .axis_o_tdata  (a_odata),
      .grant_idx     (a_gidx),
      .busy          (a_busy)
   );

   axis_packet_arbiter #(
      .AXIS_BYTES (1),
      .NUM_INPUTS (3)
   ) u_dut3 (
      .clk           (clk),
      .sresetn       (rst_n),
      .axis_i_tvalid (b_tvalid),
      .axis_i_tready (b_tready),
      .axis_i_tlast  (b_tlast),
      .axis_i_tdata  (b_tdata),
      .axis_o_tready (b_oready),
      .axis_o_tvalid (b_ovalid),
      .axis_o_tlast  (b_olast),
      .axis_o_tdata  (b_odata),
      .grant_idx     (b_gidx),
      .busy          (b_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Source queues {tlast, tdata}: index n for the 4-input DUT, 16+n for the 3-input DUT.
   logic [8:0] srcq [32][$];
   logic       stall [32];
   logic       hs [32];
   logic       rand_ready;
   logic       chk_en;

   logic       m_busy [2];
   int         m_grant [2];
   int         m_ptr [2];

   logic [7:0] log0_d [$];
   logic       log0_l [$];
   int         log0_s [$];
   int         log0_t [$];
   int         log1_s [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_req(input logic [15:0] req, input int ptr, input int n);
      int s;
      for (int k = 0; k < n; k++) begin
         s = (ptr + k) % n;
         if (req[s[3:0]]) return s;
      end
      return -1;
   endfunction

   task automatic model_cycle(input int i, input int n, input logic [15:0] v,
                              input logic [15:0] l, input logic [127:0] d, input logic ordy,
                              input logic [15:0] rdy, input logic ov, input logic ol,
                              input logic [7:0] od, input logic bsy, input logic [3:0] gi);
      int g;
      int s;
      g = m_grant[i];
      if (chk_en) begin
         chk("busy", {31'd0, bsy}, {31'd0, m_busy[i]});
         if (m_busy[i]) begin
            chk("grant_idx", {28'd0, gi}, g);
            chk("o_tvalid", {31'd0, ov}, {31'd0, v[g[3:0]]});
            chk("i_tready", {16'd0, rdy}, ordy ? (32'd1 << g) : 32'd0);
            if (v[g[3:0]]) begin
               chk("o_tdata", {24'd0, od}, {24'd0, d[g*8 +: 8]});
               chk("o_tlast", {31'd0, ol}, {31'd0, l[g[3:0]]});
            end
         end else begin
            chk("o_tvalid_idle", {31'd0, ov}, 32'd0);
            chk("i_tready_idle", {16'd0, rdy}, 32'd0);
         end
      end
      if (!rst_n) begin
         m_busy[i]  = 1'b0;
         m_grant[i] = 0;
         m_ptr[i]   = 0;
      end else if (!m_busy[i]) begin
         s = first_req(v, m_ptr[i], n);
         if (s >= 0) begin
            m_busy[i]  = 1'b1;
            m_grant[i] = s;
         end
      end else if (v[g[3:0]] && ordy && l[g[3:0]]) begin
         m_busy[i] = 1'b0;
         m_ptr[i]  = (g + 1) % n;
      end
   endtask

   // Compare and log at the falling edge, where inputs and outputs are settled.
   always @(negedge clk) begin
      cyc++;
      for (int n = 0; n < 4; n++) hs[n] = a_tvalid[n] & a_tready[n];
      for (int n = 0; n < 3; n++) hs[16+n] = b_tvalid[n] & b_tready[n];
      if (a_ovalid && a_oready) begin
         log0_d.push_back(a_odata);
         log0_l.push_back(a_olast);
         log0_s.push_back(int'(a_gidx));
         log0_t.push_back(cyc);
      end
      if (b_ovalid && b_oready) log1_s.push_back(int'(b_gidx));
      model_cycle(0, 4, {12'd0, a_tvalid}, {12'd0, a_tlast}, {96'd0, a_tdata}, a_oready,
                  {12'd0, a_tready}, a_ovalid, a_olast, a_odata, a_busy, {2'd0, a_gidx});
      model_cycle(1, 3, {13'd0, b_tvalid}, {13'd0, b_tlast}, {104'd0, b_tdata}, b_oready,
                  {13'd0, b_tready}, b_ovalid, b_olast, b_odata, b_busy, {2'd0, b_gidx});
   end

   task automatic drive();
      logic [8:0] f;
      for (int n = 0; n < 4; n++) begin
         f = (srcq[n].size() > 0) ? srcq[n][0] : 9'd0;
         a_tvalid[n]       = (srcq[n].size() > 0) && !stall[n];
         a_tdata[n*8 +: 8] = f[7:0];
         a_tlast[n]        = f[8];
      end
      for (int n = 0; n < 3; n++) begin
         f = (srcq[16+n].size() > 0) ? srcq[16+n][0] : 9'd0;
         b_tvalid[n]       = (srcq[16+n].size() > 0) && !stall[16+n];
         b_tdata[n*8 +: 8] = f[7:0];
         b_tlast[n]        = f[8];
      end
      a_oready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      b_oready = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 32; k++) begin
         if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      end
      drive();
      #1;
   endtask

   task automatic push_beat(input int q, input logic [7:0] data, input logic last);
      srcq[q].push_back({last, data});
   endtask

   task automatic clear_logs();
      log0_d.delete();
      log0_l.delete();
      log0_s.delete();
      log0_t.delete();
      log1_s.delete();
   endtask

   task automatic wait_log(input int inst, input int count, input int budget, input string name);
      int k;
      k = 0;
      while (((inst == 0) ? log0_d.size() : log1_s.size()) < count && k < budget) begin
         step();
         k++;
      end
      chk({name, "_timeout"}, {31'd0, ((inst == 0) ? log0_d.size() : log1_s.size()) >= count},
          32'd1);
   endtask

   initial begin
      int src;
      int beat;
      rst_n      = 1'b0;
      rand_ready = 1'b0;
      chk_en     = 1'b0;
      for (int k = 0; k < 32; k++) begin
         stall[k] = 1'b0;
         hs[k]    = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         m_busy[i]  = 1'b0;
         m_grant[i] = 0;
         m_ptr[i]   = 0;
      end

      // Reset with every source requesting: two 2-beat packets each, data src*16+beat.
      for (int s = 0; s < 4; s++)
         for (int b = 0; b < 4; b++) push_beat(s, 8'(s * 16 + b), (b % 2) == 1);
      drive();
      step();
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_tvalid_stim", {28'd0, a_tvalid}, 32'hF);
         chk("rst_tready", {28'd0, a_tready}, 32'd0);
         chk("rst_ovalid", {31'd0, a_ovalid}, 32'd0);
         chk("rst_busy", {31'd0, a_busy}, 32'd0);
      end
      rst_n = 1'b1;
      step();
      chk("rel_busy", {31'd0, a_busy}, 32'd1);
      chk("rel_grant", {30'd0, a_gidx}, 32'd0);

      // Round robin 0,1,2,3,0,... with one idle cycle between packets.
      wait_log(0, 16, 100, "rr");
      for (int k = 0; k < 16 && k < log0_d.size(); k++) begin
         src  = (k / 2) % 4;
         beat = (k / 8) * 2 + (k % 2);
         chk("rr_src", log0_s[k], src);
         chk("rr_data", {24'd0, log0_d[k]}, src * 16 + beat);
         chk("rr_last", {31'd0, log0_l[k]}, k % 2);
         if (k > 0) chk("rr_gap", log0_t[k] - log0_t[k-1], (k % 2 == 1) ? 1 : 2);
      end
      clear_logs();

      // Backpressure: random sink ready, one 5-beat packet on source 1.
      rand_ready = 1'b1;
      for (int b = 0; b < 5; b++) push_beat(1, 8'hA0 + 8'(b), b == 4);
      drive();
      wait_log(0, 5, 200, "bp");
      rand_ready = 1'b0;
      drive();
      repeat (5) step();
      chk("bp_count", log0_d.size(), 5);
      for (int k = 0; k < 5 && k < log0_d.size(); k++) begin
         chk("bp_data", {24'd0, log0_d[k]}, 32'hA0 + k);
         chk("bp_last", {31'd0, log0_l[k]}, (k == 4) ? 1 : 0);
         chk("bp_src", log0_s[k], 1);
      end
      clear_logs();

      // Granted source 2 stalls for 4 cycles after beat 1 while source 3 waits.
      for (int b = 0; b < 4; b++) push_beat(2, 8'hB0 + 8'(b), b == 3);
      push_beat(3, 8'hC0, 1'b1);
      drive();
      wait_log(0, 2, 50, "stall_pre");
      stall[2] = 1'b1;
      drive();
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("stall_busy", {31'd0, a_busy}, 32'd1);
         chk("stall_grant", {30'd0, a_gidx}, 32'd2);
         chk("stall_tready3", {31'd0, a_tready[3]}, 32'd0);
         chk("stall_ovalid", {31'd0, a_ovalid}, 32'd0);
         step();
      end
      stall[2] = 1'b0;
      drive();
      wait_log(0, 5, 50, "stall");
      for (int k = 0; k < 5 && k < log0_d.size(); k++) begin
         chk("stall_data", {24'd0, log0_d[k]}, (k < 4) ? 32'hB0 + k : 32'hC0);
         chk("stall_src", log0_s[k], (k < 4) ? 2 : 3);
      end
      clear_logs();

      // Reset during a 4-beat packet from source 1; arbitration must restart at source 0.
      for (int b = 0; b < 4; b++) push_beat(1, 8'hD0 + 8'(b), b == 3);
      drive();
      wait_log(0, 2, 50, "mrst_pre");
      rst_n = 1'b0;
      for (int k = 0; k < 32; k++) srcq[k].delete();
      drive();
      step();
      chk("mrst_busy", {31'd0, a_busy}, 32'd0);
      chk("mrst_tready", {28'd0, a_tready}, 32'd0);
      chk("mrst_ovalid", {31'd0, a_ovalid}, 32'd0);
      clear_logs();
      push_beat(0, 8'hE0, 1'b1);
      push_beat(1, 8'hE1, 1'b1);
      push_beat(3, 8'hE3, 1'b1);
      drive();
      rst_n = 1'b1;
      step();
      chk("mrst_regrant", {30'd0, a_gidx}, 32'd0);
      chk("mrst_rebusy", {31'd0, a_busy}, 32'd1);
      wait_log(0, 3, 50, "mrst");
      for (int k = 0; k < 3 && k < log0_d.size(); k++)
         chk("mrst_src", log0_s[k], (k == 2) ? 3 : k);
      clear_logs();

      // Three-input DUT: after source 1, sources 2 and 0 alternate across the wrap.
      push_beat(17, 8'hF1, 1'b1);
      drive();
      wait_log(1, 1, 20, "wrap_pre");
      push_beat(18, 8'h21, 1'b1);
      push_beat(18, 8'h22, 1'b1);
      push_beat(16, 8'h01, 1'b1);
      push_beat(16, 8'h02, 1'b1);
      drive();
      wait_log(1, 5, 50, "wrap");
      for (int k = 0; k < 5 && k < log1_s.size(); k++)
         chk("wrap_src", log1_s[k], (k == 0) ? 1 : ((k % 2 == 1) ? 2 : 0));

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Shares one AXI-Stream sink among NUM_INPUTS AXI-Stream sources using packet-granular round-robin arbitration. A grant is held from the first beat of a packet until its tlast beat is accepted, so packets from different sources are never interleaved. The block typically sits in front of an axis_fifo, letting several producers share one buffer and downstream consumer.

## Interface
- AXIS_BYTES, 1: data bytes per beat; tdata width is AXIS_BYTES*8.
- NUM_INPUTS, 4: number of sources; legal range 2..16.
- IDX_W, $clog2(NUM_INPUTS): derived localparam for index width; not overridable.

- clk  in  1  sole clock; all logic is rising-edge.
- sresetn  in  1  synchronous, active-low reset.
- axis_i_tvalid  in  NUM_INPUTS  per-source valid; bit n belongs to source n.
- axis_i_tready  out  NUM_INPUTS  per-source ready.
- axis_i_tlast  in  NUM_INPUTS  per-source last.
- axis_i_tdata  in  NUM_INPUTS*AXIS_BYTES*8  source n occupies bits [n*AXIS_BYTES*8 +: AXIS_BYTES*8].
- axis_o_tready  in  1  sink ready.
- axis_o_tvalid  out  1  sink valid.
- axis_o_tlast  out  1  sink last.
- axis_o_tdata  out  AXIS_BYTES*8  sink data.
- grant_idx  out  IDX_W  index of the source currently granted; valid only while busy=1.
- busy  out  1  high while a packet is in flight (state GRANT).

## Operation
- Two-state FSM: IDLE, GRANT. Registers: state, grant_idx, rr_ptr (IDX_W).
- IDLE: all axis_i_tready=0, axis_o_tvalid=0. If any axis_i_tvalid is set, choose the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_INPUTS. Register it into grant_idx and move to GRANT.
- GRANT: combinational pass-through of the granted source:
  - axis_o_tvalid = axis_i_tvalid[grant_idx];
  - axis_o_tlast and axis_o_tdata come from the granted source;
  - axis_i_tready[grant_idx] = axis_o_tready, all other treadys are 0.
- Leave GRANT when a beat with tlast=1 is accepted (tvalid & tready at the sink). Then state becomes IDLE and rr_ptr = (grant_idx+1) mod NUM_INPUTS. Wrap is explicit, because NUM_INPUTS need not be a power of two.
- When a granted source deasserts tvalid mid-packet, the grant is kept and the sink sees tvalid=0. There is no timeout.
- Non-granted sources are held off; their tvalid/tdata must stay stable, per AXIS rules.
- When axis_o_tvalid=0, tdata and tlast are don't-care. The bench must not check them then.

## Timing
- Reset (sresetn=0 at a clk edge) applies on that edge:
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0;
  - axis_o_tvalid=0, all axis_i_tready=0.
- Reset mid-packet abandons the packet. No tlast is synthesised. The source must also be reset.
- Arbitration latency: with a source valid in IDLE at edge k, the first beat can transfer in the cycle after edge k, i.e. one cycle of bubble.
- Each packet costs one IDLE cycle. Peak throughput is L/(L+1) beats/cycle for packets of L beats.
- Single-beat packet (tlast on first beat): GRANT lasts exactly one cycle when the sink is ready.
- Sink to source tready path is combinational through the grant mux. The sink's tready must not depend combinationally on axis_o_tvalid.
- Fairness: a continuously requesting source waits at most NUM_INPUTS-1 packets.

## Structure
- Put `axis_pkg` in a shared package. It holds the `axis_beat_t` struct parameterised via typedef in the user (tdata, tlast), the FSM state enum `arb_state_t`, and the function `rr_next(ptr, n)` for the wrapping increment.
- Sub-module `rr_priority_select` is combinational. It takes a request vector and a pointer, and returns found plus index. It is reused by future arbiters.
- Top level holds the FSM, registers and the output/ready muxes.

## Test plan
- Reset then idle: hold sresetn=0 for 3 cycles with all tvalid=1. Required: all treadys=0, axis_o_tvalid=0, busy=0. After release, grant_idx=0 and busy=1 one cycle later.
- Round-robin: 4 sources each continuously offer 2-beat packets, data n*16+beat. Required: output order is src 0,1,2,3,0,... with no interleaving, and exactly one idle cycle between packets.
- Wrap and skip: NUM_INPUTS=3, only sources 2 and 0 request, rr_ptr=2 after src1's packet. Required: grant order 2,0,2,0, and rr_ptr wraps 2→0.
- Backpressure: random axis_o_tready at 50% and a 5-beat packet 0xA0..0xA4. Required: all 5 beats arrive in order with tlast only on 0xA4, and no beat is duplicated or dropped.
- Mid-packet source stall: the granted source drops tvalid for 4 cycles after beat 1. Required: the grant is held, busy=1, and other requesters see tready=0 throughout.
- Reset mid-packet: assert sresetn=0 on beat 2 of 4. Required: next cycle busy=0 and treadys=0, and after release arbitration restarts from source 0.
